// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: reads a one-byte word-count header, assembles
// little-endian 32-bit words and writes them into instruction memory while holding the core.
module instr_mem_loader #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        we,
    output logic [31:0] wa,
    output logic [31:0] wd,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int          IDX_W   = $clog2(DEPTH) + 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic [7:0]       count_q, count_d;
    logic [31:0]      wd_q, wd_d;

    logic xfer;
    logic hdr_zero;
    logic hdr_over;
    logic last_word;

    // Outputs decode from registered state only, so nothing on an input reaches an output.
    assign byte_ready = (state_q == HEADER) || (state_q == DATA);
    assign we         = (state_q == WRITE);
    assign busy       = (state_q == HEADER) || (state_q == DATA) || (state_q == WRITE);
    assign cpu_hold   = busy;
    assign done       = (state_q == DONE);
    assign error      = (state_q == ERR);
    assign wa         = {{(30 - IDX_W){1'b0}}, word_idx_q, 2'b00};
    assign wd         = wd_q;

    assign xfer      = byte_valid && byte_ready;
    assign hdr_zero  = (byte_in == 8'd0);
    assign hdr_over  = ({24'd0, byte_in} > DEPTH_U);
    assign last_word = ((32'(word_idx_q) + 32'd1) == {24'd0, count_q});

    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        count_d    = count_q;
        wd_d       = wd_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = HEADER;
                end
            end

            HEADER: begin
                if (xfer) begin
                    count_d    = byte_in;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                    if (hdr_zero) begin
                        state_d = DONE;
                    end else if (hdr_over) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end

            // First byte of each word lands in the least significant lane.
            DATA: begin
                if (xfer) begin
                    case (byte_idx_q)
                        2'd0:    wd_d[7:0]   = byte_in;
                        2'd1:    wd_d[15:8]  = byte_in;
                        2'd2:    wd_d[23:16] = byte_in;
                        default: wd_d[31:24] = byte_in;
                    endcase
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end

            WRITE: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    state_d    = DATA;
                    word_idx_d = word_idx_q + {{(IDX_W - 1){1'b0}}, 1'b1};
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            count_q    <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            count_q    <= count_d;
            wd_q       <= wd_d;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: table-driven loads, hand-written
// corner sequences and random loads scored against a queue-based image model.
module tb_instr_mem_loader;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    instr_mem_loader #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .we         (we),
        .wa         (wa),
        .wd         (wd),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        int          header;
        int          gap;
        bit          timed;
        bit          exp_done;
        bit          exp_err;
        int          exp_writes;
        bit          use_img;
        logic [63:0] img;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          edge_count = 0;
    int          start_edge = 0;
    int          wr_count = 0;
    int          mon_n = 0;
    bit          mon_timed = 1'b0;
    logic        prev_we = 1'b0;
    logic [31:0] last_wa = '0;
    wr_t         exp_wr[$];
    logic [7:0]  tx_q[$];

    always @(posedge clk) edge_count <= edge_count + 1;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Write scoreboard plus cycle-exact status checks relative to the start edge.
    int   cyc;
    logic exp_hold;
    logic exp_dn;
    wr_t  e;
    initial forever begin
        @(negedge clk);
        cyc = edge_count - start_edge + 1;
        if (we) begin
            check_output("we_back_to_back", 64'(prev_we), 64'd0);
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_we actual wa=%0h wd=%0h required no write", wa, wd);
            end else begin
                e = exp_wr.pop_front();
                check_output("write_addr", 64'(wa), 64'(e.addr));
                check_output("write_data", 64'(wd), 64'(e.data));
                if (mon_timed) check_output("write_cycle", 64'(cyc), 64'(6 + 5 * wr_count));
            end
            wr_count++;
            last_wa = wa;
        end
        if (mon_timed && cyc >= 1) begin
            exp_hold = (cyc <= 5 * mon_n + 1);
            exp_dn   = (cyc >= 5 * mon_n + 2);
            check_output("status_timing", {60'd0, cpu_hold, busy, done, error},
                         {60'd0, exp_hold, exp_hold, exp_dn, 1'b0});
        end
        prev_we = we;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start_edge = edge_count + 1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Reference model: header byte, then 4*N payload bytes; word w is bytes 4w..4w+3, LSB first.
    task automatic prepare(input vec_t v);
        int nbytes;
        wr_t w;
        tx_q.delete();
        exp_wr.delete();
        tx_q.push_back(8'(v.header));
        nbytes = (v.header >= 1 && v.header <= DEPTH) ? 4 * v.header : 0;
        for (int i = 0; i < nbytes; i++) begin
            if (v.use_img) tx_q.push_back(v.img[8 * i +: 8]);
            else           tx_q.push_back(8'($urandom));
        end
        for (int k = 0; k < nbytes / 4; k++) begin
            w.addr = 32'(4 * k);
            w.data = {tx_q[4 * k + 4], tx_q[4 * k + 3], tx_q[4 * k + 2], tx_q[4 * k + 1]};
            exp_wr.push_back(w);
        end
        wr_count = 0;
    endtask

    task automatic apply_stimulus(input int gap, input int max_xfers, input int budget, output bit timeout);
        int   sent;
        int   k;
        logic xfer;
        sent = 0;
        k = 0;
        timeout = 1'b0;
        while (sent < max_xfers) begin
            if (k >= budget) begin
                timeout = 1'b1;
                break;
            end
            byte_in = tx_q[sent];
            case (gap)
                0:       byte_valid = 1'b1;
                1:       byte_valid = (k % 2 == 0);
                default: byte_valid = ($urandom_range(0, 3) != 0);
            endcase
            @(negedge clk);
            xfer = byte_valid && byte_ready;
            @(posedge clk);
            #1;
            if (xfer) sent++;
            k++;
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_finish(input int budget);
        int k;
        k = 0;
        while (!(done || error) && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_output("finish_within_budget", 64'(done || error), 64'd1);
    endtask

    task automatic finish_checks(input vec_t v);
        check_output("done_flag", 64'(done), 64'(v.exp_done));
        check_output("error_flag", 64'(error), 64'(v.exp_err));
        check_output("write_count", 64'(wr_count), 64'(v.exp_writes));
        check_output("pending_writes", 64'(exp_wr.size()), 64'd0);
        byte_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("ready_after_load", 64'(byte_ready), 64'd0);
        end
        byte_valid = 1'b0;
        @(posedge clk);
        #1;
        mon_timed = 1'b0;
    endtask

    task automatic run_load(input vec_t v);
        bit to;
        mon_timed = 1'b0;
        prepare(v);
        pulse_start();
        mon_n = v.header;
        mon_timed = v.timed;
        apply_stimulus(v.gap, tx_q.size(), 5000, to);
        check_output("stream_timeout", 64'(to), 64'd0);
        wait_finish(50);
        finish_checks(v);
    endtask

    vec_t vecs[6];
    vec_t img2;
    vec_t img1;
    vec_t rv;
    bit   to_main;
    int   n;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        byte_in = 8'd0;
        byte_valid = 1'b0;

        img2 = '{header: 2, gap: 0, timed: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 2,
                 use_img: 1'b1, img: 64'hE1A06285_E3A0500F};
        img1 = '{header: 1, gap: 0, timed: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 1,
                 use_img: 1'b1, img: 64'h00000000_E3A0F000};
        vecs[0] = img2;
        vecs[1] = img2;
        vecs[1].gap = 1;
        vecs[1].timed = 1'b0;
        vecs[2] = '{header: 0, gap: 0, timed: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 0,
                    use_img: 1'b0, img: 64'd0};
        vecs[3] = '{header: 65, gap: 0, timed: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_writes: 0,
                    use_img: 1'b0, img: 64'd0};
        vecs[4] = '{header: 64, gap: 0, timed: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_writes: 64,
                    use_img: 1'b0, img: 64'd0};
        vecs[5] = img1;

        repeat (3) @(posedge clk);
        #1;
        check_output("reset_status", {58'd0, byte_ready, we, cpu_hold, busy, done, error}, 64'd0);
        check_output("reset_wa", 64'(wa), 64'd0);
        check_output("reset_wd", 64'(wd), 64'd0);
        byte_valid = 1'b1;
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("idle_ignores_bytes", {62'd0, byte_ready, busy}, 64'd0);
        end
        byte_valid = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            $display("[TB] table load %0d header=%0d gap=%0d", i, vecs[i].header, vecs[i].gap);
            run_load(vecs[i]);
            if (vecs[i].header == DEPTH) check_output("last_wa_depth", 64'(last_wa), 64'd252);
        end

        // Asynchronous reset in the middle of word 1, between clock edges.
        prepare(img2);
        pulse_start();
        apply_stimulus(0, 7, 100, to_main);
        check_output("midword_stream_timeout", 64'(to_main), 64'd0);
        #2 reset = 1'b0;
        #1;
        check_output("async_reset_status", {58'd0, byte_ready, we, cpu_hold, busy, done, error}, 64'd0);
        check_output("async_reset_wa", 64'(wa), 64'd0);
        check_output("async_reset_wd", 64'(wd), 64'd0);
        check_output("writes_before_reset", 64'(wr_count), 64'd1);
        exp_wr.delete();
        #1 reset = 1'b1;
        byte_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("post_reset_idle", {62'd0, byte_ready, cpu_hold}, 64'd0);
        end
        byte_valid = 1'b0;
        @(posedge clk);
        #1;
        run_load(img1);

        // start pulsed while DATA is active must be ignored.
        prepare(img2);
        pulse_start();
        mon_n = 2;
        mon_timed = 1'b1;
        fork
            apply_stimulus(0, tx_q.size(), 200, to_main);
            begin
                repeat (4) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        check_output("busy_start_stream_timeout", 64'(to_main), 64'd0);
        wait_finish(50);
        finish_checks(img2);
        run_load(img1);

        for (int r = 0; r < 6; r++) begin
            n = $urandom_range(0, 70);
            rv = '{header: n, gap: 2, timed: 1'b0, exp_done: (n <= DEPTH), exp_err: (n > DEPTH),
                   exp_writes: (n <= DEPTH) ? n : 0, use_img: 1'b0, img: 64'd0};
            $display("[TB] random load %0d header=%0d", r, n);
            run_load(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

- Writes a program image into the instruction memory word array from a byte stream.
- Accepts a valid/ready byte stream, reads a one-byte word-count header, assembles little-endian 32-bit instruction words, and issues one write per word on a byte-addressed write port (word index = address/4, matching the fetch-side read).
- Asserts `cpu_hold` while loading, so the core fetches only once a complete image is in memory.

## Interface

Parameters
- `DEPTH`, default 64: instruction memory size in words. Legal header counts are 1..DEPTH.

Ports (clock and reset first)
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a load. Ignored while busy.
- `byte_in`  in  8  stream data.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader accepts a byte. A transfer occurs when `byte_valid && byte_ready` at a rising edge.
- `we`  out  1  instruction-memory write strobe, one cycle per word.
- `wa`  out  32  write byte address = word_index*4; bits [1:0] always 0.
- `wd`  out  32  write data (assembled instruction).
- `cpu_hold`  out  1  high while a load is in progress.
- `busy`  out  1  high in HEADER, DATA and WRITE.
- `done`  out  1  image loaded; held until next `start`.
- `error`  out  1  header count > DEPTH; held until next `start`.

## Operation

- States are IDLE, HEADER, DATA, WRITE, DONE and ERR. All outputs are registered or decoded from state only; there is no combinational path from input to output.
- Reset (reset low, asynchronous) forces:
  - state = IDLE;
  - `byte_ready`, `we`, `cpu_hold`, `busy`, `done`, `error` = 0;
  - `wa`, `wd`, word index, byte index and count = 0.
- IDLE, DONE, ERR: `byte_ready` = 0. A `start` moves to HEADER and clears `done` and `error`.
- HEADER: `byte_ready` = 1. On transfer, N = `byte_in`:
  - N == 0 → DONE, no writes.
  - N > DEPTH → ERR, no writes.
  - Otherwise → DATA with word index = 0 and byte index = 0.
- DATA: `byte_ready` = 1.
  - A transfer at byte index k (0..3) loads `wd[8k+7:8k]`. The first byte is the least significant.
  - The byte index increments modulo 4.
  - The transfer at k = 3 moves to WRITE.
- WRITE: `byte_ready` = 0; `we` = 1 for exactly this one cycle; `wa` = word index × 4; `wd` holds the assembled word.
  - Next state is DONE if word index + 1 == N, else DATA with the word index incremented.
- DONE: `done` = 1. ERR: `error` = 1.
- `cpu_hold` = `busy` = 1 in HEADER, DATA and WRITE, and 0 otherwise.
- `start` is ignored while busy.
- `byte_valid` gaps stall the loader; there is no timeout.
- Bytes offered in IDLE, DONE or ERR are not accepted (`byte_ready` = 0).
- Word index width is clog2(DEPTH)+1. It never exceeds DEPTH-1 when `we` is high.
- A new `start` after DONE or ERR reloads from word 0 and overwrites earlier contents.

## Timing

- `start` sampled at edge t → HEADER from t+1 → `byte_ready` high in cycle t+1.
- With `byte_valid` held high:
  - header accepted at t+1;
  - word w bytes accepted at t+2+5w .. t+5+5w;
  - `we` high in cycle t+6+5w;
  - DONE, `done` = 1 and `cpu_hold` = 0 from cycle t+2+5N.
- Total load latency from `start` is 5N+2 cycles; throughput is 5 cycles per word.
- `we` is never high in two consecutive cycles. `wa` and `wd` are stable throughout the `we` cycle.
- The memory captures on the same rising edge that ends the `we` cycle.
- Reset asserted mid-load takes effect immediately, without waiting for a clock edge:
  - `we` drops and any partially assembled word is discarded;
  - `cpu_hold` deasserts;
  - after reset release the loader stays in IDLE until `start`.

## Test plan

- **Reset values:** assert reset asynchronously between edges → all outputs 0 immediately; `byte_ready` stays 0 with `byte_valid` = 1 and no `start`.
- **Two-word load, continuous stream:** header 2, bytes 0F 50 A0 E3 85 62 A0 E1 →
  - `we` at cycle 6 with `wa` = 0, `wd` = E3A0500F;
  - `we` at cycle 11 with `wa` = 4, `wd` = E1A06285;
  - `done` = 1 at cycle 12;
  - `cpu_hold` high in cycles 1–11 (cycles counted from `start`).
- **Stalled stream:** same image with `byte_valid` toggling 1/0 each cycle → same two writes with identical `wa`/`wd`; `done` only after the last write; no extra `we`.
- **Header boundaries:**
  - 0 → `done` = 1 at cycle 2, no `we`;
  - 65 (DEPTH = 64) → `error` = 1, no `we`;
  - 64 → last write at `wa` = 252, then `done`.
- **Reset mid-word:** reset after 2 data bytes of word 1 → no further `we`, `cpu_hold` = 0. A following `start` with header 1, bytes 00 F0 A0 E3 → single write `wa` = 0, `wd` = E3A0F000.
- **`start` while busy:** `start` pulsed during DATA → ignored; load completes normally. A `start` in DONE clears `done` and reloads from `wa` = 0.
